// File: rtl/vc_fifo.sv
// Multi-VC flit FIFO: VCS independent circular buffers, one push and one pop per cycle.
// Define VC_FIFO_ERR_EN to build the sticky {overflow, underflow} error flags.
module vc_fifo #(
    parameter int WIDTH    = 18,
    parameter int DEPTH    = 16,
    parameter int VCS      = 4,
    parameter int AF_LEVEL = DEPTH - 2,
    localparam int VW      = $clog2(VCS),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [VW-1:0]     wr_vc,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              read,
    input  logic [VW-1:0]     rd_vc,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic [VCS-1:0]    empty,
    output logic [VCS-1:0]    full,
    output logic [VCS-1:0]    almost_full,
    output logic [VCS*CW-1:0] count,
    output logic [1:0]        err
);

    localparam int AW = CW - 1;

    logic [WIDTH-1:0] mem    [VCS][DEPTH];
    logic [CW-1:0]    wr_ptr [VCS];
    logic [CW-1:0]    rd_ptr [VCS];
    logic [CW-1:0]    occ    [VCS];

    logic push_ok;
    logic pop_ok;

    // Flags come from the registered pointers only, so they never follow write/read.
    for (genvar i = 0; i < VCS; i++) begin : g_flags
        assign occ[i]             = wr_ptr[i] - rd_ptr[i];
        assign empty[i]           = (wr_ptr[i] == rd_ptr[i]);
        assign full[i]            = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        assign almost_full[i]     = (occ[i] >= CW'(AF_LEVEL));
        assign count[i*CW +: CW]  = occ[i];
    end

    // A push to a full VC is dropped even when that VC is popped in the same cycle.
    assign push_ok = write && !full[wr_vc];
    assign pop_ok  = read && !empty[rd_vc];

    // Storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_vc][wr_ptr[wr_vc][AW-1:0]] <= data_in;
        end
    end

    // Per-VC pointer advance; the extra top bit toggles on every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VCS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VCS; i++) begin
                if (push_ok && (wr_vc == VW'(i))) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop_ok && (rd_vc == VW'(i))) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
        end
    end

    // Registered pop data; an ignored pop holds the previous flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[rd_vc][rd_ptr[rd_vc][AW-1:0]];
            end
        end
    end

`ifdef VC_FIFO_ERR_EN
    logic ovf;
    logic udf;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (write && full[wr_vc]) begin
                ovf <= 1'b1;
            end
            if (read && empty[rd_vc]) begin
                udf <= 1'b1;
            end
        end
    end

    assign err = {ovf, udf};
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// Bench for vc_fifo: directed scenarios plus random traffic against a per-VC queue model.
// Build with or without VC_FIFO_ERR_EN; the expected err follows the same macro.
module tb_vc_fifo;

    localparam int W  = 18;
    localparam int D  = 16;
    localparam int V  = 4;
    localparam int AF = D - 2;
    localparam int VW = 2;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          write;
    logic [VW-1:0] wr_vc;
    logic [W-1:0]  data_in;
    logic          read;
    logic [VW-1:0] rd_vc;
    logic [W-1:0]  data_out;
    logic          rd_valid;
    logic [V-1:0]  empty;
    logic [V-1:0]  full;
    logic [V-1:0]  almost_full;
    logic [V*CW-1:0] count;
    logic [1:0]    err;

    vc_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .wr_vc      (wr_vc),
        .data_in    (data_in),
        .read       (read),
        .rd_vc      (rd_vc),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mq [V][$];
    logic [W-1:0] exp_dout;
    logic         exp_valid;
    logic [1:0]   exp_err;
    int           checks = 0;
    int           errors = 0;
    bit           saw_poison;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [V-1:0]    e_empty;
        logic [V-1:0]    e_full;
        logic [V-1:0]    e_af;
        logic [V*CW-1:0] e_cnt;
        for (int i = 0; i < V; i++) begin
            e_empty[i]          = (mq[i].size() == 0);
            e_full[i]           = (mq[i].size() == D);
            e_af[i]             = (mq[i].size() >= AF);
            e_cnt[i*CW +: CW]   = CW'(mq[i].size());
        end
        chk({tag, ".data_out"}, 64'(data_out), 64'(exp_dout));
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(exp_valid));
        chk({tag, ".empty"}, 64'(empty), 64'(e_empty));
        chk({tag, ".full"}, 64'(full), 64'(e_full));
        chk({tag, ".almost_full"}, 64'(almost_full), 64'(e_af));
        chk({tag, ".count"}, 64'(count), 64'(e_cnt));
        chk({tag, ".err"}, 64'(err), 64'(exp_err));
    endtask

    task automatic model_reset();
        for (int i = 0; i < V; i++) mq[i].delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_err   = 2'b00;
    endtask

    task automatic cyc(input string tag, input logic w, input logic [VW-1:0] wv,
                       input logic [W-1:0] d, input logic r,
                       input logic [VW-1:0] rv);
        bit wok;
        bit pok;
        write   = w;
        wr_vc   = wv;
        data_in = d;
        read    = r;
        rd_vc   = rv;
        @(posedge clk);
        wok = w && (mq[wv].size() < D);
        pok = r && (mq[rv].size() > 0);
        exp_valid = pok;
        if (pok) begin
            exp_dout = mq[rv].pop_front();
            if (exp_dout == 18'h3FFFF) saw_poison = 1'b1;
        end
        if (wok) mq[wv].push_back(d);
`ifdef VC_FIFO_ERR_EN
        if (w && !wok) exp_err[1] = 1'b1;
        if (r && !pok) exp_err[0] = 1'b1;
`endif
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        write = 1'b0; wr_vc = '0; data_in = '0;
        read = 1'b0; rd_vc = '0;
        saw_poison = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill VC2, overflow it with a marker, then drain it in order.
        for (int i = 0; i < D; i++)
            cyc("fill_vc2", 1'b1, 2'd2, W'($urandom_range(0, 18'h3FFFE)), 1'b0, 2'd0);
        chk("full_vc2", 64'(full), 64'(4'b0100));
        cyc("ovf_vc2", 1'b1, 2'd2, 18'h3FFFF, 1'b0, 2'd0);
        for (int i = 0; i < D; i++)
            cyc("drain_vc2", 1'b0, 2'd0, '0, 1'b1, 2'd2);
        chk("poison_never_popped", 64'(saw_poison), 64'(0));
        chk("all_empty", 64'(empty), 64'(4'b1111));

        // Pop from empty VC1 is ignored.
        cyc("pop_empty_vc1", 1'b0, 2'd0, '0, 1'b1, 2'd1);

        // Interleaved VC0/VC3 pushes, then drain VC3 before VC0.
        for (int v = 1; v <= 8; v++)
            cyc("ilv_push", 1'b1, (v % 2 == 1) ? 2'd0 : 2'd3, W'(v), 1'b0, 2'd0);
        for (int i = 0; i < 4; i++)
            cyc("ilv_pop3", 1'b0, 2'd0, '0, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++)
            cyc("ilv_pop0", 1'b0, 2'd0, '0, 1'b1, 2'd0);

        // Steady-state push+pop on VC0 at occupancy 5, wrapping the pointers.
        for (int i = 0; i < 5; i++)
            cyc("pre5", 1'b1, 2'd0, W'($urandom), 1'b0, 2'd0);
        for (int i = 0; i < 20; i++)
            cyc("pushpop_vc0", 1'b1, 2'd0, W'($urandom), 1'b1, 2'd0);
        for (int i = 0; i < 5; i++)
            cyc("post5", 1'b0, 2'd0, '0, 1'b1, 2'd0);

        // Random traffic, biased toward few VCs so the full/empty edges get hit.
        for (int i = 0; i < 400; i++)
            cyc("random", 1'($urandom_range(0, 2) != 0), VW'($urandom_range(0, 1)),
                W'($urandom), 1'($urandom_range(0, 1)), VW'($urandom_range(0, 1)));
        for (int i = 0; i < 2 * D; i++)
            cyc("random_drain", 1'b0, 2'd0, '0, 1'b1, VW'(i % 2));

        // Asynchronous reset mid-burst with VC1 holding 7 flits.
        for (int i = 0; i < 7; i++)
            cyc("fill_vc1", 1'b1, 2'd1, W'($urandom), 1'b0, 2'd0);
        write = 1'b1; wr_vc = 2'd1; data_in = W'($urandom);
        read = 1'b1; rd_vc = 2'd1;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        write = 1'b0; read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc("pop_after_reset", 1'b0, 2'd0, '0, 1'b1, 2'd1);

        write = 1'b0; read = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameter WIDTH, default 18, flit width in bits.
REQ-002 Parameter DEPTH, default 16, entries per virtual channel; power of two, >= 2.
REQ-003 Parameter VCS, default 4, number of virtual channels; power of two, >= 2.
REQ-004 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-005 Local parameter VW = $clog2(VCS); CW = $clog2(DEPTH)+1.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 write  input  1  push request.
REQ-009 wr_vc  input  VW  target VC of push.
REQ-010 data_in  input  WIDTH  push data.
REQ-011 read  input  1  pop request.
REQ-012 rd_vc  input  VW  source VC of pop.
REQ-013 data_out  output  WIDTH  registered pop data.
REQ-014 rd_valid  output  1  data_out holds a newly popped flit this cycle.
REQ-015 empty  output  VCS  per-VC empty flag, bit i = VC i.
REQ-016 full  output  VCS  per-VC full flag.
REQ-017 almost_full  output  VCS  per-VC occupancy >= AF_LEVEL.
REQ-018 count  output  VCS*CW  per-VC occupancy, VC i in bits [i*CW +: CW].
REQ-019 err  output  2  {overflow, underflow} sticky flags (see Configuration).

Function
REQ-020 Each VC SHALL be an independent circular buffer of DEPTH entries with read/write pointers carrying one extra wrap bit.
REQ-021 Push accepted iff write=1 and full[wr_vc]=0; data_in stored at that VC's write pointer; pointer increments by 1, wrapping DEPTH-1 -> 0 and toggling the wrap bit.
REQ-022 Push to a full VC SHALL be dropped; no state change, even if the same VC is popped that cycle.
REQ-023 Pop accepted iff read=1 and empty[rd_vc]=0; data_out loads the head entry on that edge; rd_valid=1 for the following cycle; read pointer increments with wrap.
REQ-024 Pop from an empty VC SHALL be ignored: rd_valid=0, data_out holds its previous value; no bypass of a same-cycle push.
REQ-025 Simultaneous accepted push and pop to the same VC SHALL leave count unchanged; to different VCs, each count updates independently.
REQ-026 Latency: a flit pushed at edge N is poppable at edge N+1 and appears on data_out after edge N+1.
REQ-027 empty, full, almost_full, count SHALL be derived from pointers only, valid in the cycle after each edge, never glitching combinationally from write/read.
REQ-028 full[i] = (wrap bits differ, addresses equal); empty[i] = (pointers identical).
REQ-029 FIFO order SHALL be preserved per VC; no ordering between VCs.

Reset
REQ-030 On rst=1, asynchronously: all pointers 0, empty=all ones, full=0, almost_full=0, count=0, data_out=0, rd_valid=0, err=0.
REQ-031 Reset mid-operation discards all stored flits; storage array contents need not be cleared.
REQ-032 First accepted operation is on the first posedge after rst deasserts.

Configuration
REQ-033 With macro VC_FIFO_ERR_EN defined: err[1] sets on a push to a full VC, err[0] on a pop from an empty VC; both sticky until rst.
REQ-034 Without VC_FIFO_ERR_EN: err SHALL be constant 0 and no error logic synthesised; all other behaviour identical.

Verification
REQ-035 Reset, then push 16 random flits to VC2 -> full=4'b0100, count VC2=16, almost_full[2] set from 14th push; pop all 16 -> data matches in order, empty=4'b1111.
REQ-036 17th push to full VC2 with data 18'h3FFFF -> dropped; popped data never 18'h3FFFF unless pushed; err=2'b10 with VC_FIFO_ERR_EN, 2'b00 without.
REQ-037 Pop VC1 when empty -> rd_valid=0, data_out unchanged, err[0]=1 with macro.
REQ-038 Interleave pushes to VC0 and VC3 (values 1..8 alternating), pop VC3 then VC0 -> each VC returns its own flits in order; other VCs' counts stay 0.
REQ-039 VC0 holding 5 flits, push and pop VC0 in the same cycle for 20 cycles -> count stays 5, pointers wrap, output order correct.
REQ-040 Assert rst mid-burst with VC1 holding 7 flits -> flags reset immediately without clock edge; subsequent pop of VC1 ignored.
